// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: state codes,
// instruction field constants, ALUOp codes and the per-state control words.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  // Bit positions inside the 16-bit control bus
  localparam int BIT_JUMP      = 15;
  localparam int BIT_IORD      = 14;
  localparam int BIT_MEMWRITE  = 13;
  localparam int BIT_IRWRITE   = 12;
  localparam int BIT_PCWRITE   = 11;
  localparam int BIT_BRANCH    = 10;
  localparam int BIT_PCSRC     = 9;
  localparam int BIT_ALUOP_MSB = 8;
  localparam int BIT_ALUOP_LSB = 6;
  localparam int BIT_SRCB_MSB  = 5;
  localparam int BIT_SRCB_LSB  = 4;
  localparam int BIT_ALUSRCA   = 3;
  localparam int BIT_REGWRITE  = 2;
  localparam int BIT_MEMTOREG  = 1;
  localparam int BIT_REGDST    = 0;

  localparam logic [15:0] CTRL_FETCH      = 16'h1890;
  localparam logic [15:0] CTRL_DECODE     = 16'h00B0;
  localparam logic [15:0] CTRL_MEMADR     = 16'h00A8;
  localparam logic [15:0] CTRL_MEMREAD    = 16'h4000;
  localparam logic [15:0] CTRL_MEMWB      = 16'h0006;
  localparam logic [15:0] CTRL_MEMWRITE   = 16'h6000;
  localparam logic [15:0] CTRL_EXEC_BASE  = 16'h0008;
  localparam logic [15:0] CTRL_ALUWB      = 16'h0005;
  localparam logic [15:0] CTRL_BRANCH     = 16'h0788;
  localparam logic [15:0] CTRL_ADDIEXEC   = 16'h00A8;
  localparam logic [15:0] CTRL_ADDIWB     = 16'h0004;
  localparam logic [15:0] CTRL_JUMP       = 16'h8800;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct decoder: maps funct to an ALUOp code and flags unsupported
// functs so DECODE can reject them before EXECUTE is entered.
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] aluop_o,
  output logic       legal_o
);

  always_comb begin
    aluop_o = ALUOP_ADD;
    legal_o = 1'b1;
    case (funct_i)
      FN_ADD:  aluop_o = ALUOP_ADD;
      FN_SUB:  aluop_o = ALUOP_SUB;
      FN_AND:  aluop_o = ALUOP_AND;
      FN_OR:   aluop_o = ALUOP_OR;
      FN_SLT:  aluop_o = ALUOP_SLT;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore main control FSM for the multicycle MIPS datapath: sequences each
// instruction and drives the 16-bit control bus plus debug event outputs.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   zero,
  output logic [15:0]            control_signal,
  output logic [3:0]             state_o,
  output logic                   instr_retired,
  output logic                   branch_taken,
  output logic                   illegal_instr,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] retiredCount_q, retiredCount_d;
  logic [2:0]             aluOp;
  logic                   functLegal;
  logic                   illegalDecode;
  logic                   retireState;
  logic [15:0]            ctrlWord;

  alu_op_decoder u_aluOpDecoder (
    .funct_i (funct),
    .aluop_o (aluOp),
    .legal_o (functLegal)
  );

  always_comb begin
    state_d       = S_FETCH;
    illegalDecode = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (functLegal) state_d = S_EXECUTE;
            else            illegalDecode = 1'b1;
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEXEC;
          OP_J:    state_d = S_JUMP;
          default: illegalDecode = 1'b1;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Control word is a pure decode of the state; only EXECUTE also looks at funct
  always_comb begin
    ctrlWord    = '0;
    retireState = 1'b0;
    case (state_q)
      S_FETCH:    ctrlWord = CTRL_FETCH;
      S_DECODE:   ctrlWord = CTRL_DECODE;
      S_MEMADR:   ctrlWord = CTRL_MEMADR;
      S_MEMREAD:  ctrlWord = CTRL_MEMREAD;
      S_MEMWB: begin
        ctrlWord    = CTRL_MEMWB;
        retireState = 1'b1;
      end
      S_MEMWRITE: begin
        ctrlWord    = CTRL_MEMWRITE;
        retireState = 1'b1;
      end
      S_EXECUTE: begin
        ctrlWord = CTRL_EXEC_BASE;
        ctrlWord[BIT_ALUOP_MSB:BIT_ALUOP_LSB] = aluOp;
      end
      S_ALUWB: begin
        ctrlWord    = CTRL_ALUWB;
        retireState = 1'b1;
      end
      S_BRANCH: begin
        ctrlWord    = CTRL_BRANCH;
        retireState = 1'b1;
      end
      S_ADDIEXEC: ctrlWord = CTRL_ADDIEXEC;
      S_ADDIWB: begin
        ctrlWord    = CTRL_ADDIWB;
        retireState = 1'b1;
      end
      S_JUMP: begin
        ctrlWord    = CTRL_JUMP;
        retireState = 1'b1;
      end
      default: ctrlWord = '0;
    endcase
  end

  always_comb begin
    retiredCount_d = retiredCount_q;
    if (retireState) retiredCount_d = retiredCount_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      retiredCount_q <= '0;
    end else begin
      state_q        <= state_d;
      retiredCount_q <= retiredCount_d;
    end
  end

  // Reset masks every event output so nothing downstream sees a half instruction
  assign control_signal = rst ? '0 : ctrlWord;
  assign instr_retired  = ~rst & retireState;
  assign branch_taken   = ~rst & (state_q == S_BRANCH) & zero;
  assign illegal_instr  = ~rst & (state_q == S_DECODE) & illegalDecode;
  assign state_o        = state_q;
  assign retired_count  = retiredCount_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Moore-style main control state machine for the multicycle MIPS datapath; sits directly upstream of the datapath top and drives its 16-bit control bus. Sequences each instruction through fetch/decode/execute/memory/writeback states from the IR opcode and funct fields. Also reports the current state, retirement/branch/illegal-instruction events and a retired-instruction counter for debug and verification.

Parameters:
COUNT_WIDTH, 32, width of retired_count; wraps modulo 2^COUNT_WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
opcode  input  6  IR[31:26]; valid from DECODE onward
funct  input  6  IR[5:0]; used only when opcode = 000000
zero  input  1  datapath ALU zero flag, combinational from the current ALU result
control_signal  output  16  bit map: [15] Jump, [14] IorD, [13] MemWrite, [12] IRWrite, [11] PCWrite, [10] Branch, [9] PCSrc, [8:6] ALUOp, [5:4] ALUSrcB, [3] ALUSrcA, [2] RegWrite, [1] MemtoReg, [0] RegDst
state_o  output  4  current state encoding
instr_retired  output  1  1-cycle pulse in the final state of every legal instruction
branch_taken  output  1  high in BRANCH when zero = 1
illegal_instr  output  1  1-cycle pulse in DECODE on an unsupported opcode or funct
retired_count  output  COUNT_WIDTH  count of retired instructions

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state <= FETCH and retired_count <= 0.
- While rst = 1, control_signal, instr_retired, branch_taken and illegal_instr are forced to 0. state_o still reads 0 (FETCH).
- Reset has priority mid-instruction: the next cycle is FETCH and no retire pulse is produced.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next clock and drive control_signal = 0.
- control_signal is a combinational decode of the state register (and of funct in EXECUTE). There is no added latency.
- Control values per state:
  - FETCH 0x1890 (IRWrite, PCWrite, ALUSrcB=01, ADD)
  - DECODE 0x00B0 (ALUSrcB=11, ADD: branch target)
  - MEMADR 0x00A8
  - MEMREAD 0x4000
  - MEMWB 0x0006
  - MEMWRITE 0x6000
  - EXECUTE 0x0008 | (aluop<<6)
  - ALUWB 0x0005
  - BRANCH 0x0788 (Branch, PCSrc, ALUSrcA, SUB)
  - ADDIEXEC 0x00A8
  - ADDIWB 0x0004
  - JUMP 0x8800
- ALUOp codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Funct map: 100000 gives ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE branches on opcode: 100011 (lw) or 101011 (sw) to MEMADR; 000000 with legal funct to EXECUTE; 000100 (beq) to BRANCH; 001000 (addi) to ADDIEXEC; 000010 (j) to JUMP.
  - Any other opcode, or R-type with an unknown funct, pulses illegal_instr and returns to FETCH (instruction skipped, no retire).
  - MEMADR goes to MEMREAD for lw, to MEMWRITE for sw.
  - MEMREAD goes to MEMWB.
  - EXECUTE goes to ALUWB.
  - ADDIEXEC goes to ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.
- Cycle counts, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- instr_retired is high in MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH and JUMP. retired_count increments on the clock edge ending each of those states.
- The counter wraps from all-ones to 0 with no flag.
- branch_taken = (state == BRANCH) & zero. It does not alter the state sequence, because the datapath gates PC enable with Branch&Zero.
- opcode and funct are sampled combinationally, and only in DECODE, MEMADR and EXECUTE. Changes in other states are ignored.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode and funct constants
  - ALUOp codes
  - control_signal bit-index constants
  - the per-state control word constants above
- One natural sub-module, alu_op_decoder: combinational, funct[5:0] in, aluop[2:0] and legal out. It is used by both the DECODE legality check and EXECUTE.

Test Plan:
1. Reset then release: with rst=1 for 2 clocks, control_signal=0 and retired_count=0. On the first cycle after release, state_o=0 and control_signal=0x1890; the next cycle gives state_o=1 and 0x00B0.
2. lw (opcode 100011): state_o sequence is 0,1,2,3,4 with control 0x1890, 0x00B0, 0x00A8, 0x4000, 0x0006. instr_retired pulses only in cycle 5; retired_count goes 0 to 1.
3. R-type sub (funct 100010), then slt (funct 101010): EXECUTE drives 0x0188 for sub and 0x01C8 for slt, followed by ALUWB 0x0005; 4 cycles each, and retired_count advances by 2.
4. beq with zero=1, then with zero=0: BRANCH drives 0x0788 in both cases. branch_taken=1 only in the first. Each takes 3 cycles and both retire.
5. Illegal opcode 111111, then R-type with funct 000111: each gives FETCH, DECODE, FETCH. illegal_instr pulses once per instruction and retired_count is unchanged.
6. Assert rst during MEMREAD of an lw: the next state is FETCH and there is no retire pulse. With COUNT_WIDTH=4 and 16 j instructions, retired_count wraps 15 to 0.
